// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver.
// Segment vectors use bit order {g,f,e,d,c,b,a} and are active-low.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry n holds the active-low pattern for decimal digit n.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD code to active-low segment decoder.
// Codes A-F have no glyph and produce a blank pattern.
`timescale 1ns/1ps
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg_n
);

    always_comb begin
        o_seg_n = SEG_BLANK;
        if (i_code < 4'd10) begin
            o_seg_n = SEG_TABLE[i_code];
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with dead-time blanking,
// leading-zero blanking and a one-entry pending buffer applied at frame boundaries.
`timescale 1ns/1ps
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 6000,
    parameter int BLANK_CYC  = 300
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   bcd_in,
    input  logic                      load_valid,
    output logic                      load_ready,
    input  logic                      lzb_en,
    output logic [6:0]                seg_n,
    output logic [NUM_DIGITS-1:0]     an_n,
    output logic                      frame_done
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW    = 4 * NUM_DIGITS;

    logic [CNT_W-1:0]      r_slot_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [DW-1:0]         r_disp;
    logic [DW-1:0]         r_pend;
    logic                  r_pend_full;
    logic [6:0]            r_seg_n;
    logic [NUM_DIGITS-1:0] r_an_n;
    logic                  r_frame_done;

    logic [3:0]            w_digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] w_sup;
    logic [NUM_DIGITS-1:0] w_an_next;
    logic                  w_run;
    logic                  w_slot_end;
    logic                  w_frame_end;
    logic                  w_accept;
    logic                  w_blank;
    logic [3:0]            w_cur;
    logic [6:0]            w_dec;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign w_digit[gi] = r_disp[4*gi +: 4];
    end

    // Suppression runs from the top digit down and stops at the first non-zero code.
    always_comb begin
        w_run = lzb_en;
        w_sup = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_run    = w_run && (w_digit[i] == 4'd0);
            w_sup[i] = w_run && (i != 0);
        end
    end

    assign w_slot_end  = (r_slot_cnt == CNT_W'(SCAN_DIV - 1));
    assign w_frame_end = w_slot_end && (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign load_ready  = !r_pend_full;
    assign w_accept    = load_valid && !r_pend_full;
    assign w_cur       = w_digit[r_idx];
    assign w_blank     = (r_slot_cnt < CNT_W'(BLANK_CYC)) || w_sup[r_idx];

    seg7_decode u_decode (
        .i_code  (w_cur),
        .o_seg_n (w_dec)
    );

    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_an_next[i] = !(!w_blank && (r_idx == IDX_W'(i)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_cnt   <= '0;
            r_idx        <= '0;
            r_disp       <= '0;
            r_pend       <= '0;
            r_pend_full  <= 1'b0;
            r_seg_n      <= SEG_BLANK;
            r_an_n       <= '1;
            r_frame_done <= 1'b0;
        end else begin
            if (w_slot_end) begin
                r_slot_cnt <= '0;
                r_idx      <= w_frame_end ? '0 : r_idx + 1'b1;
            end else begin
                r_slot_cnt <= r_slot_cnt + 1'b1;
            end

            // Accept and swap are exclusive: accept needs an empty buffer, swap a full one.
            if (w_frame_end && r_pend_full) begin
                r_disp      <= r_pend;
                r_pend_full <= 1'b0;
            end else if (w_accept) begin
                r_pend      <= bcd_in;
                r_pend_full <= 1'b1;
            end

            r_seg_n      <= w_blank ? SEG_BLANK : w_dec;
            r_an_n       <= w_an_next;
            r_frame_done <= w_frame_end;
        end
    end

    assign seg_n      = r_seg_n;
    assign an_n       = r_an_n;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized and directed bench for seg7_scan_driver, checked every cycle against a
// frame-position model of the display (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2).
`timescale 1ns/1ps
module tb_seg7_scan_driver;

    localparam int ND    = 4;
    localparam int SCAN  = 8;
    localparam int BLANK = 2;
    localparam int FRAME = ND * SCAN;

    logic        clk;
    logic        rst_n;
    logic [15:0] bcd_in;
    logic        load_valid;
    logic        load_ready;
    logic        lzb_en;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        frame_done;

    seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SCAN), .BLANK_CYC(BLANK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd_in     (bcd_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .lzb_en     (lzb_en),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

    int n_checks = 0;
    int n_errors = 0;

    // Model state: displayed word, pending word, cycles since reset release.
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    logic        m_full;
    int          k;
    int          lit_cnt [4];
    int          fd_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s observed %h expected %h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_disp = '0;
        m_pend = '0;
        m_full = 1'b0;
        k      = 0;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) lit_cnt[i] = 0;
        fd_cnt = 0;
    endtask

    // One clock: predict outputs from the frame position, advance the model, compare.
    task automatic step(output logic acc);
        logic        lzb_s;
        logic [15:0] bcd_s;
        logic [3:0]  dig, e_an;
        logic [6:0]  e_seg;
        logic        e_fd, sup;
        int          p, d, s;
        acc   = load_valid && !m_full;
        lzb_s = lzb_en;
        bcd_s = bcd_in;
        @(posedge clk);
        p = k % FRAME;
        k++;
        d = p / SCAN;
        s = p % SCAN;
        dig = 4'((m_disp >> (4 * d)) & 16'hF);
        sup = lzb_s && (d != 0) && ((m_disp >> (4 * d)) == 16'd0);
        if (s < BLANK || sup) begin
            e_an  = 4'hF;
            e_seg = 7'h7F;
        end else begin
            e_an  = ~(4'b0001 << d);
            e_seg = seg_tab[dig];
        end
        e_fd = (p == FRAME - 1);
        if (e_fd && m_full) begin
            m_disp = m_pend;
            m_full = 1'b0;
        end
        if (acc) begin
            m_pend = bcd_s;
            m_full = 1'b1;
            $display("load %h accepted at cycle %0d", bcd_s, k);
        end
        #1;
        check("an_n", 32'(an_n), 32'(e_an));
        check("seg_n", 32'(seg_n), 32'(e_seg));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        check("load_ready", 32'(load_ready), 32'(!m_full));
        for (int i = 0; i < 4; i++) if (!an_n[i]) lit_cnt[i]++;
        if (frame_done) fd_cnt++;
    endtask

    task automatic run(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    task automatic load(input logic [15:0] v);
        logic acc;
        int   n;
        n = 0;
        acc = 1'b0;
        bcd_in = v;
        load_valid = 1'b1;
        while (!acc && n < 200) begin
            step(acc);
            n++;
        end
        load_valid = 1'b0;
        if (!acc) check("load_timeout", 32'(acc), 32'd1);
    endtask

    task automatic wait_fd();
        logic acc;
        int   n;
        n = 0;
        do begin
            step(acc);
            n++;
        end while (!frame_done && n < 100);
        if (!frame_done) check("frame_done_timeout", 32'(frame_done), 32'd1);
    endtask

    task automatic wait_an(input logic [3:0] an, input logic [6:0] seg, input string tag);
        logic acc;
        int   n;
        n = 0;
        while (an_n !== an && n < 64) begin
            step(acc);
            n++;
        end
        if (an_n === an) check(tag, 32'(seg_n), 32'(seg));
        else             check({tag, "_timeout"}, 32'(an_n), 32'(an));
    endtask

    task automatic check_frame_lit(input int c0, input int c1, input int c2, input int c3,
                                   input string tag);
        wait_fd();
        clear_counts();
        run(FRAME);
        check({tag, "_lit0"}, 32'(lit_cnt[0]), 32'(c0));
        check({tag, "_lit1"}, 32'(lit_cnt[1]), 32'(c1));
        check({tag, "_lit2"}, 32'(lit_cnt[2]), 32'(c2));
        check({tag, "_lit3"}, 32'(lit_cnt[3]), 32'(c3));
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        for (int i = 0; i < 4; i++) begin
            v[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        end
        return v;
    endfunction

    initial begin
        logic acc;
        rst_n = 1'b0;
        bcd_in = '0;
        load_valid = 1'b0;
        lzb_en = 1'b0;
        model_reset();
        clear_counts();
        repeat (3) @(negedge clk);
        check("rst_seg_n", 32'(seg_n), 32'h7F);
        check("rst_an_n", 32'(an_n), 32'hF);
        check("rst_load_ready", 32'(load_ready), 32'd1);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;

        // First frame after reset: "0000", 6 lit cycles per digit, one frame_done.
        clear_counts();
        run(FRAME);
        check("first_lit0", 32'(lit_cnt[0]), 32'd6);
        check("first_lit3", 32'(lit_cnt[3]), 32'd6);
        check("first_fd_cnt", 32'(fd_cnt), 32'd1);
        clear_counts();
        run(2 * FRAME);
        check("fd_period", 32'(fd_cnt), 32'd2);

        load(16'h1234);
        wait_fd();
        wait_an(4'hE, 7'h19, "d0_4");
        wait_an(4'hD, 7'h30, "d1_3");
        wait_an(4'hB, 7'h24, "d2_2");
        wait_an(4'h7, 7'h79, "d3_1");

        lzb_en = 1'b1;
        load(16'h0070);
        check_frame_lit(6, 6, 0, 0, "lzb_0070");
        wait_an(4'hD, 7'h78, "lzb_0070_d1");
        wait_an(4'hE, 7'h40, "lzb_0070_d0");
        load(16'h0000);
        check_frame_lit(6, 0, 0, 0, "lzb_0000");
        wait_an(4'hE, 7'h40, "lzb_0000_d0");
        load(16'h0A05);
        check_frame_lit(6, 6, 6, 0, "lzb_0A05");
        wait_an(4'hB, 7'h7F, "lzb_0A05_d2");
        wait_an(4'hD, 7'h40, "lzb_0A05_d1");
        wait_an(4'hE, 7'h12, "lzb_0A05_d0");

        // Back-to-back loads mid-frame: second one waits for the boundary swap.
        lzb_en = 1'b0;
        wait_fd();
        run(5);
        load(16'h1111);
        load(16'h2222);
        wait_fd();
        wait_an(4'hE, 7'h24, "bp_2222_d0");
        wait_an(4'h7, 7'h24, "bp_2222_d3");

        for (int i = 0; i < 1500; i++) begin
            if (!load_valid && $urandom_range(0, 19) == 0) begin
                bcd_in = rand_bcd();
                load_valid = 1'b1;
            end
            if ($urandom_range(0, 199) == 0) lzb_en = ~lzb_en;
            step(acc);
            if (acc) load_valid = 1'b0;
        end
        load_valid = 1'b0;

        // Asynchronous reset while digit 1 is lit, with a word still pending.
        lzb_en = 1'b0;
        load(16'h5555);
        wait_fd();
        load(16'h9999);
        wait_an(4'hD, 7'h12, "pre_rst_d1");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_seg_n", 32'(seg_n), 32'h7F);
        check("async_an_n", 32'(an_n), 32'hF);
        check("async_load_ready", 32'(load_ready), 32'd1);
        check("async_frame_done", 32'(frame_done), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_an(4'hE, 7'h40, "post_rst_d0");
        run(3 * FRAME);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
